// File: rtl/show_ahead_fifo.sv
// Show-ahead (first-word-fall-through) FIFO with occupancy count.
// With INIT_FREE_LIST=1 it resets holding IDs 0..DEPTH-1 and serves as an ID free list.
module show_ahead_fifo #(
    parameter int WIDTH          = 32,
    parameter int LOG_DEPTH      = 4,
    parameter int INIT_FREE_LIST = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   size
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_COUNT  = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] RESET_COUNT = (INIT_FREE_LIST != 0) ? FULL_COUNT : '0;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q,  count_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign size    = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Both flags are judged on the pre-edge count, so a push while full is
    // rejected even when a pop in the same cycle frees a slot.
    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= RESET_COUNT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is reset too: the free list needs its ID
    // contents at reset, and a cleared array keeps rd_data free of X.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (INIT_FREE_LIST != 0) begin
                    mem_q[i] <= WIDTH'(i);
                end else begin
                    mem_q[i] <= '0;
                end
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_show_ahead_fifo.sv
// Directed self-checking bench for show_ahead_fifo: a plain 48-bit queue
// instance and a 4-bit free-list instance share one clock.
module tb_show_ahead_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Plain queue instance
    logic        a_rstn, a_wr, a_rd;
    logic [47:0] a_wd, a_rdata;
    logic        a_full, a_empty;
    logic [4:0]  a_size;

    // Free-list instance
    logic        b_rstn, b_wr, b_rd;
    logic [3:0]  b_wd, b_rdata;
    logic        b_full, b_empty;
    logic [4:0]  b_size;

    int total = 0;
    int bad   = 0;

    show_ahead_fifo #(.WIDTH(48), .LOG_DEPTH(4), .INIT_FREE_LIST(0)) dut_a (
        .clk(clk), .rstn(a_rstn), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
        .rd_data(a_rdata), .full(a_full), .empty(a_empty), .size(a_size)
    );

    show_ahead_fifo #(.WIDTH(4), .LOG_DEPTH(4), .INIT_FREE_LIST(1)) dut_b (
        .clk(clk), .rstn(b_rstn), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd),
        .rd_data(b_rdata), .full(b_full), .empty(b_empty), .size(b_size)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [47:0] d);
        a_wr = 1'b1; a_wd = d;
        tick();
        a_wr = 1'b0;
    endtask

    initial begin
        a_rstn = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wd = '0;
        b_rstn = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wd = '0;
        #12;
        check("a_rst_empty", 64'(a_empty), 64'd1);
        check("a_rst_full",  64'(a_full),  64'd0);
        check("a_rst_size",  64'(a_size),  64'd0);
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        tick();

        // 1: single push becomes visible right after its edge
        a_push(48'hA1);
        check("t1_empty", 64'(a_empty), 64'd0);
        check("t1_data",  64'(a_rdata), 64'hA1);
        check("t1_size",  64'(a_size),  64'd1);
        a_rd = 1'b1; tick(); a_rd = 1'b0;
        check("t1_drained", 64'(a_empty), 64'd1);

        // 2: fill to full, overflow push ignored, drain in order
        for (int i = 0; i < 16; i++) a_push(48'(i));
        check("t2_full", 64'(a_full), 64'd1);
        check("t2_size", 64'(a_size), 64'd16);
        a_push(48'h99);
        check("t2_ovf_size", 64'(a_size), 64'd16);
        check("t2_ovf_head", 64'(a_rdata), 64'd0);
        a_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_pop%0d", i), 64'(a_rdata), 64'(i));
            tick();
        end
        a_rd = 1'b0;
        check("t2_empty", 64'(a_empty), 64'd1);
        check("t2_size0", 64'(a_size),  64'd0);

        // 3: steady push+pop at occupancy 5 across pointer wrap
        for (int i = 0; i < 5; i++) a_push(48'(100 + i));
        a_wr = 1'b1; a_rd = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_wd = 48'(200 + k);
            check($sformatf("t3_head%0d", k), 64'(a_rdata),
                  (k < 5) ? 64'(100 + k) : 64'(200 + k - 5));
            tick();
            check($sformatf("t3_size%0d", k), 64'(a_size), 64'd5);
        end
        a_wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_tail%0d", k), 64'(a_rdata), 64'(205 + k));
            tick();
        end
        a_rd = 1'b0;
        check("t3_empty", 64'(a_empty), 64'd1);

        // 4a: pops on empty are ignored and do not move the read pointer
        a_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_uflow%0d", k), 64'(a_size), 64'd0);
        end
        a_rd = 1'b0;
        a_push(48'h55);
        check("t4_head_after_uflow", 64'(a_rdata), 64'h55);
        a_rd = 1'b1; tick(); a_rd = 1'b0;

        // 4b: push+pop on empty -> push wins, no bypass
        a_wr = 1'b1; a_rd = 1'b1; a_wd = 48'h88;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        check("t4_empty_both_size", 64'(a_size),  64'd1);
        check("t4_empty_both_data", 64'(a_rdata), 64'h88);
        a_rd = 1'b1; tick(); a_rd = 1'b0;

        // 4c: push+pop on full -> pop wins, pushed value not stored
        for (int i = 0; i < 16; i++) a_push(48'h300 + 48'(i));
        a_wr = 1'b1; a_rd = 1'b1; a_wd = 48'h77;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        check("t4_full_both_size", 64'(a_size), 64'd15);
        check("t4_full_both_full", 64'(a_full), 64'd0);
        a_rd = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t4_drain%0d", i), 64'(a_rdata), 64'h300 + 64'(i));
            tick();
        end
        a_rd = 1'b0;
        check("t4_drained", 64'(a_empty), 64'd1);

        // 6: asynchronous reset mid-stream at occupancy 7
        for (int i = 0; i < 7; i++) a_push(48'h400 + 48'(i));
        check("t6_pre_size", 64'(a_size), 64'd7);
        a_wr = 1'b1; a_wd = 48'h500;
        #2;
        a_rstn = 1'b0;
        #1;
        check("t6_async_size",  64'(a_size),  64'd0);
        check("t6_async_empty", 64'(a_empty), 64'd1);
        check("t6_async_full",  64'(a_full),  64'd0);
        a_wr = 1'b0;
        #1;
        a_rstn = 1'b1;
        tick();
        check("t6_post_size", 64'(a_size), 64'd0);

        // 5: free list
        check("t5_rst_full", 64'(b_full),  64'd1);
        check("t5_rst_size", 64'(b_size),  64'd16);
        check("t5_rst_head", 64'(b_rdata), 64'd0);
        b_rd = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        b_rd = 1'b0;
        check("t5_pop3_head", 64'(b_rdata), 64'd3);
        check("t5_pop3_size", 64'(b_size),  64'd13);
        b_wr = 1'b1; b_wd = 4'd1;
        tick();
        b_wr = 1'b0;
        check("t5_ret_size", 64'(b_size), 64'd14);
        b_rd = 1'b1;
        for (int k = 0; k < 14; k++) begin
            check($sformatf("t5_id%0d", k), 64'(b_rdata), (k < 13) ? 64'(k + 3) : 64'd1);
            tick();
        end
        b_rd = 1'b0;
        check("t5_empty", 64'(b_empty), 64'd1);
        #3;
        b_rstn = 1'b0;
        #1;
        check("t5_rerst_full", 64'(b_full),  64'd1);
        check("t5_rerst_size", 64'(b_size),  64'd16);
        check("t5_rerst_head", 64'(b_rdata), 64'd0);
        b_rstn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
